// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front end and run-state shadow for the stopwatch.
// Debounces mode/start/lap buttons, cycles the display select, issues the
// one-cycle start/stop and clear pulses, and generates the centisecond tick.
// Optional lap capture is built only when SW_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV     = 1_000_000,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic [5:0] sw_hours,
  input  logic [5:0] sw_minutes,
  input  logic [5:0] sw_seconds,
  input  logic [6:0] sw_ms,
  output logic [1:0] sel,
  output logic       sw_start,
  output logic       sw_tick,
  output logic       sw_clear,
  output logic       run,
  output logic       sat,
  output logic       lap_valid,
  output logic [5:0] lap_hours,
  output logic [5:0] lap_minutes,
  output logic [5:0] lap_seconds,
  output logic [6:0] lap_ms
);

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PW  = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [PW-1:0]  PRES_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_HALTED
  } state_t;

  // Button vector order: [0]=mode, [1]=start, [2]=lap.
  logic [2:0]     btn_raw;
  logic [2:0]     sync1, sync2, deb, deb_d, press;
  logic [DBW-1:0] db_cnt [3];

  logic   mode_press, start_press, lap_press;
  state_t state, state_nxt;
  logic   start_nxt, clear_nxt, pres_clr;
  logic [PW-1:0] pres;

  assign btn_raw = {btn_lap, btn_start, btn_mode};

  // Synchronize raw buttons and accept a new level after DEBOUNCE_CYC
  // consecutive differing samples; any matching sample restarts the count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Presses are rising edges of the debounced level; start/lap need sel==3,
  // judged against sel before any same-cycle mode increment.
  assign press       = deb & ~deb_d;
  assign mode_press  = press[0];
  assign start_press = press[1] && (sel == 2'd3);
  assign lap_press   = press[2] && (sel == 2'd3);

`ifdef SW_LAP_EN
  logic capture;
`endif

  // Next-state and pulse decode for the run shadow; start wins over lap.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    start_nxt = 1'b0;
    clear_nxt = 1'b0;
    pres_clr  = 1'b0;
`ifdef SW_LAP_EN
    capture   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start_press) begin
          state_nxt = S_RUNNING;
          start_nxt = 1'b1;
          pres_clr  = 1'b1;
        end
      end
      S_RUNNING: begin
        if (start_press) begin
          state_nxt = S_HALTED;
          start_nxt = 1'b1;
        end else if (lap_press) begin
`ifdef SW_LAP_EN
          capture = 1'b1;
`endif
        end
      end
      S_HALTED: begin
        if (start_press) begin
          state_nxt = S_RUNNING;
          start_nxt = 1'b1;
        end else if (lap_press) begin
          state_nxt = S_IDLE;
          clear_nxt = 1'b1;
          pres_clr  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run-state register and the registered one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      sw_start <= 1'b0;
      sw_clear <= 1'b0;
    end else begin
      state    <= state_nxt;
      sw_start <= start_nxt;
      sw_clear <= clear_nxt;
    end
  end

  assign run = (state == S_RUNNING);

  // Display mode select cycles on every mode press.
  always_ff @(posedge clk) begin
    if (!reset_n) sel <= 2'd0;
    else if (mode_press) sel <= sel + 2'd1;
  end

  // Centisecond prescaler: counts only while staying in RUNNING, holds across
  // a halt, and never ticks on the edge that leaves RUNNING.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pres    <= '0;
      sw_tick <= 1'b0;
    end else begin
      sw_tick <= 1'b0;
      if (pres_clr) begin
        pres <= '0;
      end else if (state == S_RUNNING && state_nxt == S_RUNNING) begin
        if (pres == PRES_LAST) begin
          pres    <= '0;
          sw_tick <= 1'b1;
        end else begin
          pres <= pres + PW'(1);
        end
      end
    end
  end

  assign sat = (sw_hours == 6'd23) && (sw_minutes == 6'd59) &&
               (sw_seconds == 6'd59) && (sw_ms == 7'd99);

`ifdef SW_LAP_EN
  // Lap capture registers: load on a RUNNING lap, wipe on a clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lap_valid   <= 1'b0;
      lap_hours   <= '0;
      lap_minutes <= '0;
      lap_seconds <= '0;
      lap_ms      <= '0;
    end else if (clear_nxt) begin
      lap_valid   <= 1'b0;
      lap_hours   <= '0;
      lap_minutes <= '0;
      lap_seconds <= '0;
      lap_ms      <= '0;
    end else if (capture) begin
      lap_valid   <= 1'b1;
      lap_hours   <= sw_hours;
      lap_minutes <= sw_minutes;
      lap_seconds <= sw_seconds;
      lap_ms      <= sw_ms;
    end
  end
`else
  assign lap_valid   = 1'b0;
  assign lap_hours   = '0;
  assign lap_minutes = '0;
  assign lap_seconds = '0;
  assign lap_ms      = '0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYC=4, TICK_DIV=10.
// A clean press driven just after edge k acts on edge k+7.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] btns;  // {lap, start, mode}
  logic [5:0] sw_hours, sw_minutes, sw_seconds;
  logic [6:0] sw_ms;
  logic [1:0] sel;
  logic       sw_start, sw_tick, sw_clear, run, sat, lap_valid;
  logic [5:0] lap_hours, lap_minutes, lap_seconds;
  logic [6:0] lap_ms;

`ifdef SW_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_miss = 0;
  int start_cnt = 0, clear_cnt = 0, tick_cnt = 0, wide_cnt = 0, tick_out = 0;
  logic prev_start = 1'b0, prev_clear = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btns[0]), .btn_start(btns[1]), .btn_lap(btns[2]),
    .sw_hours(sw_hours), .sw_minutes(sw_minutes),
    .sw_seconds(sw_seconds), .sw_ms(sw_ms),
    .sel(sel), .sw_start(sw_start), .sw_tick(sw_tick), .sw_clear(sw_clear),
    .run(run), .sat(sat), .lap_valid(lap_valid),
    .lap_hours(lap_hours), .lap_minutes(lap_minutes),
    .lap_seconds(lap_seconds), .lap_ms(lap_ms)
  );

  // Pulse bookkeeping sampled mid-cycle.
  always @(negedge clk) begin
    if (sw_start) start_cnt++;
    if (sw_clear) clear_cnt++;
    if (sw_tick) tick_cnt++;
    if ((sw_start && prev_start) || (sw_clear && prev_clear)) wide_cnt++;
    if (sw_tick && !run) tick_out++;
    prev_start = sw_start;
    prev_clear = sw_clear;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] b);
    btns = b;
    step(7);
  endtask

  task automatic release_all();
    btns = 3'b000;
    step(8);
  endtask

  task automatic set_sw(input int h, input int m, input int s, input int c);
    sw_hours   = 6'(h);
    sw_minutes = 6'(m);
    sw_seconds = 6'(s);
    sw_ms      = 7'(c);
  endtask

  int s0, c0, t0;
  bit found;

  initial begin
    reset_n = 1'b0;
    btns    = 3'b000;
    set_sw(0, 0, 0, 0);
    step(3);
    check("rst_sel", sel, 0);
    check("rst_run", run, 0);
    check("rst_start", sw_start, 0);
    check("rst_clear", sw_clear, 0);
    check("rst_tick", sw_tick, 0);
    check("rst_lap_valid", lap_valid, 0);
    check("rst_sat", sat, 0);
    reset_n = 1'b1;
    step(1);

    // Three mode presses: sel 1,2,3, each landing 7 cycles after the raw edge.
    for (int i = 1; i <= 3; i++) begin
      btns = 3'b001;
      step(6);
      check("sel_before", sel, i - 1);
      step(1);
      check("sel_after", sel, i);
      release_all();
    end
    check("mode_no_start", start_cnt, 0);

    // Start from IDLE: one pulse, RUNNING, tick 10 cycles later, then every 10.
    press(3'b010);
    check("start_pulse", sw_start, 1);
    check("run_on", run, 1);
    btns = 3'b000;
    step(1);
    check("start_width", sw_start, 0);
    step(8);
    check("tick_not_yet", sw_tick, 0);
    step(1);
    check("first_tick", sw_tick, 1);
    step(9);
    check("tick_gap", sw_tick, 0);
    step(1);
    check("tick_period", sw_tick, 1);
    check("start_count", start_cnt, 1);

    // 3-cycle glitch is shorter than the debounce window.
    btns = 3'b010;
    step(3);
    btns = 3'b000;
    step(10);
    check("glitch_no_start", start_cnt, 1);
    check("glitch_run", run, 1);

    // Saturation compare.
    #1;
    set_sw(23, 59, 59, 99);
    #1;
    check("sat_on", sat, 1);
    set_sw(23, 59, 59, 98);
    #1;
    check("sat_off", sat, 0);

    // Lap capture and overwrite while RUNNING.
    set_sw(0, 1, 2, 37);
    press(3'b100);
    check("lap1_valid", lap_valid, LAP_EN ? 1 : 0);
    check("lap1_hours", lap_hours, 0);
    check("lap1_minutes", lap_minutes, LAP_EN ? 1 : 0);
    check("lap1_seconds", lap_seconds, LAP_EN ? 2 : 0);
    check("lap1_ms", lap_ms, LAP_EN ? 37 : 0);
    check("lap1_run", run, 1);
    release_all();
    set_sw(0, 1, 5, 0);
    press(3'b100);
    check("lap2_seconds", lap_seconds, LAP_EN ? 5 : 0);
    check("lap2_ms", lap_ms, 0);
    check("lap2_valid", lap_valid, LAP_EN ? 1 : 0);
    release_all();

    // Align to a tick, halt 7 cycles later (prescaler held at 6).
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(1);
      if (sw_tick) found = 1'b1;
    end
    check("tick_align", found, 1);
    press(3'b010);
    check("halt_pulse", sw_start, 1);
    check("halt_run", run, 0);
    btns = 3'b000;
    t0 = tick_cnt;
    step(25);
    check("halted_no_tick", tick_cnt, t0);

    // Resume: remaining 4 counts to the next tick.
    press(3'b010);
    check("resume_pulse", sw_start, 1);
    check("resume_run", run, 1);
    btns = 3'b000;
    step(3);
    check("resume_tick_early", sw_tick, 0);
    step(1);
    check("resume_tick", sw_tick, 1);
    step(8);

    // Halt, then lap clears back to IDLE.
    press(3'b010);
    check("halt2_run", run, 0);
    release_all();
    c0 = clear_cnt;
    press(3'b100);
    check("clear_pulse", sw_clear, 1);
    check("clear_run", run, 0);
    check("clear_lap_valid", lap_valid, 0);
    check("clear_lap_seconds", lap_seconds, 0);
    btns = 3'b000;
    step(1);
    check("clear_width", sw_clear, 0);
    step(7);
    check("clear_count", clear_cnt, c0 + 1);

    // Lap in IDLE does nothing.
    press(3'b100);
    check("idle_lap_clear", sw_clear, 0);
    release_all();
    check("idle_lap_count", clear_cnt, c0 + 1);

    // start+lap while RUNNING: halt, no capture.
    press(3'b010);
    release_all();
    set_sw(0, 2, 3, 4);
    press(3'b110);
    check("sl_pulse", sw_start, 1);
    check("sl_run", run, 0);
    check("sl_lap_valid", lap_valid, 0);
    check("sl_lap_ms", lap_ms, 0);
    check("sl_no_clear", sw_clear, 0);
    release_all();
    press(3'b100);
    check("sl_then_clear", sw_clear, 1);
    release_all();

    // mode+start at sel=2: start discarded, sel becomes 3.
    for (int i = 0; i < 3; i++) begin
      press(3'b001);
      release_all();
    end
    check("sel_wrap_to_2", sel, 2);
    s0 = start_cnt;
    press(3'b011);
    check("ms_sel", sel, 3);
    check("ms_no_start", sw_start, 0);
    check("ms_run", run, 0);
    release_all();
    check("ms_start_count", start_cnt, s0);

    // Reset mid-RUNNING with lap held.
    press(3'b010);
    check("pre_rst_run", run, 1);
    release_all();
    set_sw(0, 4, 5, 6);
    btns = 3'b100;
    step(7);
    check("pre_rst_lap_valid", lap_valid, LAP_EN ? 1 : 0);
    s0 = start_cnt;
    c0 = clear_cnt;
    reset_n = 1'b0;
    step(1);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_run", run, 0);
    check("mid_rst_lap_valid", lap_valid, 0);
    check("mid_rst_lap_ms", lap_ms, 0);
    check("mid_rst_start", sw_start, 0);
    check("mid_rst_clear", sw_clear, 0);
    check("mid_rst_tick", sw_tick, 0);
    step(2);
    reset_n = 1'b1;
    step(12);
    check("post_rst_run", run, 0);
    check("post_rst_lap_valid", lap_valid, 0);
    check("post_rst_starts", start_cnt, s0);
    check("post_rst_clears", clear_cnt, c0);
    release_all();

    check("pulse_width_1", wide_cnt, 0);
    check("tick_only_running", tick_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end controller for the stopwatch datapath. It debounces the three user buttons and cycles the display-mode select. It issues the single-cycle start/stop pulse that the stopwatch requires and generates the centisecond advance enable. It also owns lap (split) capture and the stopwatch clear. It sits between the board buttons and the stopwatch instance, with a run-state shadow that tracks the stopwatch's STOPPED/RUNNING toggle.

## Interface
- TICK_DIV, default 1_000_000: clk cycles per centisecond tick (100 MHz → 10 ms); minimum 2.
- DEBOUNCE_CYC, default 500_000: consecutive stable synchronized samples needed to accept a button level; minimum 1.
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- btn_mode  in  1  raw mode button, asynchronous, active high.
- btn_start  in  1  raw start/stop button, asynchronous, active high.
- btn_lap  in  1  raw lap/clear button, asynchronous, active high.
- sw_hours  in  6  stopwatch hours, 0–23.
- sw_minutes  in  6  stopwatch minutes, 0–59.
- sw_seconds  in  6  stopwatch seconds, 0–59.
- sw_ms  in  7  stopwatch centiseconds, 0–99.
- sel  out  2  display mode select; 3 = stopwatch.
- sw_start  out  1  one-cycle start/stop pulse to the stopwatch.
- sw_tick  out  1  one-cycle advance enable to the stopwatch.
- sw_clear  out  1  one-cycle clear, OR'd into the stopwatch reset.
- run  out  1  shadow state is RUNNING.
- sat  out  1  stopwatch inputs equal 23:59:59.99.
- lap_valid  out  1  lap registers hold a capture.
- lap_hours  out  6  captured hours.
- lap_minutes  out  6  captured minutes.
- lap_seconds  out  6  captured seconds.
- lap_ms  out  7  captured centiseconds.

## Operation
- Button path, per button:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level flips only after DEBOUNCE_CYC consecutive synchronized samples differ from it. Any matching sample reloads the counter.
  - A rising edge of the debounced level gives a one-cycle internal press. Release generates nothing.
- Mode: each mode press sets sel to (sel+1) mod 4. The run shadow, prescaler and lap registers are unaffected by mode changes.
- Start/lap presses act only when sel==3; otherwise they are discarded.
- Run shadow FSM, states IDLE, RUNNING, HALTED:
  - IDLE + start → RUNNING. Pulse sw_start; prescaler cleared to 0.
  - RUNNING + start → HALTED. Pulse sw_start; prescaler holds its value.
  - HALTED + start → RUNNING. Pulse sw_start; prescaler resumes from its held value.
  - RUNNING + lap → capture the sw_* inputs into lap_*; lap_valid=1. A repeated lap overwrites the capture.
  - HALTED + lap → IDLE. Pulse sw_clear; lap_valid=0; lap_* cleared to 0; prescaler cleared.
  - IDLE + lap → no action.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING.
  - sw_tick is high for exactly one cycle when count==TICK_DIV-1; count then wraps to 0.
  - sw_tick is never high outside RUNNING.
- sat: combinational compare of the sw_* inputs. It has no effect on the FSM; the stopwatch freezes itself. Ticks continue while sat=1.
- Simultaneous presses in one cycle:
  - start+lap: start acts, lap discarded.
  - mode+start or mode+lap: start/lap are evaluated against the pre-increment sel, then sel increments.
- Reset values, all outputs 0: sel=0, state IDLE, prescaler 0, lap_*=0, lap_valid=0. Debounced levels and synchronizers are 0.
- Reset asserted mid-operation overrides everything on that edge. No sw_start or sw_clear pulse is emitted by reset; the system reset clears the stopwatch itself.

## Timing
- All outputs are registered except sat.
- Raw button rising at cycle 0, held stable, with no bounce and sel==3:
  - debounced level rises at cycle DEBOUNCE_CYC+2;
  - sw_start or sw_clear, the lap_* update, and the FSM change occur at cycle DEBOUNCE_CYC+3;
  - for a mode press, sel updates at cycle DEBOUNCE_CYC+3.
- sw_start and sw_clear are exactly one cycle wide, because the stopwatch toggles every cycle start is high.
- Entering RUNNING from IDLE at cycle T gives the first sw_tick at T+TICK_DIV, then one every TICK_DIV cycles.
- A lap capture samples the sw_* values present on the same edge the FSM sees the press.

## Configuration
- SW_LAP_EN defined: lap capture as described.
- SW_LAP_EN undefined:
  - lap_* and lap_valid are tied to 0, with no capture registers;
  - a lap press in RUNNING is ignored;
  - HALTED + lap → IDLE with sw_clear still works.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, TICK_DIV=10.
- Reset, then 3 clean mode presses → sel steps 1,2,3; each update lands 7 cycles after the raw edge; no sw_start.
- sel=3: start press → a single 1-cycle sw_start, run=1; sw_tick every 10 cycles; a 3-cycle glitch on btn_start produces no pulse.
- RUNNING with sw inputs driven to 00:01:02.37, lap press → lap_*=0/1/2/37, lap_valid=1; a second lap at 00:01:05.00 overwrites.
- Start (HALTED) → sw_tick stops with the prescaler at, e.g., 6. Start again → the next tick arrives 4 cycles later. Lap in HALTED → 1-cycle sw_clear, lap_valid=0, state IDLE.
- start+lap in the same cycle while RUNNING → HALTED, no capture. mode+start with sel=2 → no sw_start; sel becomes 3.
- reset_n low mid-RUNNING with a lap held → all outputs 0 on the next edge, no pulses. Repeat without SW_LAP_EN → lap_* stay 0.
